// File: rtl/canvas_pkg.sv
// Shared constants for the canvas port sequencer slice.
//   CANVAS_ADDR_W : canvas address width, address = {y[4:0], x[4:0]}
//   CANVAS_DEPTH  : number of canvas cells
//   S_IDLE/S_CLEAR/S_READ : sequencer state encodings
package canvas_pkg;

  localparam int CANVAS_ADDR_W = 10;
  localparam int CANVAS_DEPTH  = 1024;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_CLEAR = 2'd1;
  localparam state_t S_READ  = 2'd2;

endpackage

// File: rtl/canvas_port_sequencer_if.sv
// Raster readout stream between the canvas port sequencer and its consumer
// (recognizer or UART).
//   rd_bit   : streamed pixel value
//   rd_valid : rd_bit is valid
//   rd_ready : consumer accepts rd_bit when rd_valid & rd_ready
//   rd_last  : marks the pixel at the last canvas address
// master = sequencer side, slave = consumer side.
interface canvas_port_sequencer_if;

  logic rd_bit;
  logic rd_valid;
  logic rd_ready;
  logic rd_last;

  modport master (output rd_bit, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_bit, input rd_valid, input rd_last, output rd_ready);

endinterface

// File: rtl/canvas_rd_skid.sv
// One-entry output register for the canvas readout stream.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_bit/load_last into the slot (only when slot_free)
//   flush      : drop the held beat (read abort); wins over load
//   rd_ready   : consumer ready
//   rd_valid/rd_bit/rd_last : registered stream outputs, held until accepted
//   slot_free  : the slot can take a new beat this cycle
module canvas_rd_skid (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic flush,
  input  logic load_bit,
  input  logic load_last,
  input  logic rd_ready,
  output logic rd_valid,
  output logic rd_bit,
  output logic rd_last,
  output logic slot_free
);

  assign slot_free = !rd_valid || rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_bit   <= 1'b0;
      rd_last  <= 1'b0;
    end else if (flush) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (load) begin
      rd_valid <= 1'b1;
      rd_bit   <= load_bit;
      rd_last  <= load_last;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/canvas_port_sequencer.sv
// Owner of the single read/write port of the 32x32 1-bit canvas RAM.
// Arbitrates between a full-canvas clear sweep, mouse paint writes and a
// raster readout stream. Per-cycle priority: clear sweep > paint > fetch.
//   clk, rst      : clock, synchronous active-high reset
//   clear_start   : pulse, zero the whole canvas (also aborts a readout)
//   read_start    : pulse, stream all cells out in address order
//   paint_req/paint_addr/paint_data/paint_gnt : mouse write, granted same cycle
//   ram_a/ram_d/ram_we/ram_spo : canvas RAM port (async read data)
//   rd            : readout stream (master side)
//   busy          : sequencer not idle
//   clear_done    : pulse the cycle after the final clear write
module canvas_port_sequencer
  import canvas_pkg::*;
#(
  parameter int ADDR_W = CANVAS_ADDR_W,
  parameter int DEPTH  = CANVAS_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_start,
  input  logic                    read_start,
  input  logic                    paint_req,
  input  logic [ADDR_W-1:0]       paint_addr,
  input  logic                    paint_data,
  output logic                    paint_gnt,
  output logic [ADDR_W-1:0]       ram_a,
  output logic                    ram_d,
  output logic                    ram_we,
  input  logic                    ram_spo,
  canvas_port_sequencer_if.master rd,
  output logic                    busy,
  output logic                    clear_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              fetch;
  logic              slot_free;
  logic              abort;

  assign busy  = (state != S_IDLE);
  assign abort = (state == S_READ) && clear_start;

  // Port mux. Gated by rst so a reset landing mid-sweep commits no write.
  // A beat holding rd_last blocks further fetches, so ptr never runs past
  // the last address.
  always_comb begin
    paint_gnt = 1'b0;
    ram_a     = ptr;
    ram_d     = 1'b0;
    ram_we    = 1'b0;
    fetch     = 1'b0;
    if (!rst) begin
      case (state)
        S_CLEAR: begin
          ram_we = 1'b1;
        end
        S_IDLE: begin
          if (paint_req) begin
            paint_gnt = 1'b1;
            ram_a     = paint_addr;
            ram_d     = paint_data;
            ram_we    = 1'b1;
          end
        end
        S_READ: begin
          if (paint_req) begin
            paint_gnt = 1'b1;
            ram_a     = paint_addr;
            ram_d     = paint_data;
            ram_we    = 1'b1;
          end else if (slot_free && !(rd.rd_valid && rd.rd_last)) begin
            fetch = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_start) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end else if (read_start) begin
            state <= S_READ;
            ptr   <= '0;
          end
        end
        S_CLEAR: begin
          if (clear_start) begin
            ptr <= '0;
          end else if (ptr == LAST_ADDR) begin
            state      <= S_IDLE;
            clear_done <= 1'b1;
            ptr        <= '0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        S_READ: begin
          if (clear_start) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end else begin
            if (fetch && (ptr != LAST_ADDR))
              ptr <= ptr + ADDR_W'(1);
            if (rd.rd_valid && rd.rd_ready && rd.rd_last)
              state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  canvas_rd_skid u_rd_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (fetch),
    .flush     (abort),
    .load_bit  (ram_spo),
    .load_last (ptr == LAST_ADDR),
    .rd_ready  (rd.rd_ready),
    .rd_valid  (rd.rd_valid),
    .rd_bit    (rd.rd_bit),
    .rd_last   (rd.rd_last),
    .slot_free (slot_free)
  );

endmodule
